// File: rtl/byte_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : byte_serial_adder_ctrl
// Description : Byte-serial front/back end for an external combinational
//               WIDTH-bit adder. Loads A then B (LS byte first) over a
//               valid/ready port, holds them on registered adder inputs for
//               SETTLE cycles, captures sum/carry, then streams N sum bytes
//               followed by a carry byte out over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_adder_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_cin,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  localparam int N     = WIDTH / 8;
  // Counter must index 2N input bytes; output indexing (0..N) always fits too.
  localparam int CNT_W = (2 * N > 2) ? $clog2(2 * N) : 1;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [3:0]         r_settle_cnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_op_cin;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_out_valid;
  logic [7:0]         r_out_data;

  logic [WIDTH-1:0]   w_op_a_nxt;
  logic [WIDTH-1:0]   w_op_b_nxt;
  logic [CNT_W-1:0]   w_out_idx_nxt;
  logic [7:0]         w_out_byte_nxt;

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_cin    = r_op_cin;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_out_idx_nxt = r_byte_cnt + CNT_W'(1);

  // Steer the incoming byte into the operand lane selected by the byte count.
  always_comb begin
    w_op_a_nxt = r_op_a;
    w_op_b_nxt = r_op_b;
    for (int i = 0; i < N; i++) begin
      if (r_byte_cnt == CNT_W'(i)) begin
        w_op_a_nxt[8*i +: 8] = in_data;
      end
      if (r_byte_cnt == CNT_W'(i + N)) begin
        w_op_b_nxt[8*i +: 8] = in_data;
      end
    end
  end

  // Select the byte that follows the one currently on out_data; index N is the carry byte.
  always_comb begin
    w_out_byte_nxt = {7'b0, r_cout};
    for (int i = 0; i < N; i++) begin
      if (w_out_idx_nxt == CNT_W'(i)) begin
        w_out_byte_nxt = r_sum[8*i +: 8];
      end
    end
  end

  // Load / settle / stream-out control with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_byte_cnt   <= '0;
      r_settle_cnt <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_cin     <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_op_a <= w_op_a_nxt;
            r_op_b <= w_op_b_nxt;
            if (r_byte_cnt == '0) begin
              r_op_cin <= in_cin;
            end
            if (r_byte_cnt == CNT_W'(2 * N - 1)) begin
              r_byte_cnt   <= '0;
              r_settle_cnt <= 4'(SETTLE);
              r_state      <= S_WAIT;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (r_settle_cnt == 4'd1) begin
            // Adder inputs have now been stable for SETTLE full cycles.
            r_settle_cnt <= 4'd0;
            r_sum        <= add_sum;
            r_cout       <= add_cout;
            r_out_valid  <= 1'b1;
            r_out_data   <= add_sum[7:0];
            r_byte_cnt   <= '0;
            r_state      <= S_OUT;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (r_byte_cnt == CNT_W'(N)) begin
              r_out_valid <= 1'b0;
              r_out_data  <= 8'd0;
              r_byte_cnt  <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_byte_cnt <= w_out_idx_nxt;
              r_out_data <= w_out_byte_nxt;
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serial_adder_ctrl
// Description : Self-checking bench for byte_serial_adder_ctrl. One instance
//               with SETTLE=2 and one with SETTLE=1, each driving a
//               behavioural 32-bit adder; a select line routes the shared
//               stimulus to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_adder_ctrl;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [39:0] exp;  // byte 4 = carry, bytes 3..0 = sum
    logic [7:0]  rdy;  // out_ready pattern, bit 0 first
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, in_valid, in_cin, out_ready, sel;
  logic [7:0] in_data;

  logic        ir0, ir1, ov0, ov1, bz0, bz1, oc0, oc1, co0, co1;
  logic [31:0] oa0, oa1, ob0, ob1, s0, s1;
  logic [7:0]  od0, od1;

  // Behavioural stand-in for the external combinational adder.
  assign {co0, s0} = {1'b0, oa0} + {1'b0, ob0} + {32'd0, oc0};
  assign {co1, s1} = {1'b0, oa1} + {1'b0, ob1} + {32'd0, oc1};

  logic iv0, iv1, or0, or1;
  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign or0 = out_ready & ~sel;
  assign or1 = out_ready & sel;

  byte_serial_adder_ctrl #(.WIDTH(WIDTH), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .in_cin(in_cin), .op_a(oa0), .op_b(ob0), .op_cin(oc0), .add_sum(s0),
    .add_cout(co0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(bz0)
  );

  byte_serial_adder_ctrl #(.WIDTH(WIDTH), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .in_cin(in_cin), .op_a(oa1), .op_b(ob1), .op_cin(oc1), .add_sum(s1),
    .add_cout(co1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1)
  );

  logic        w_in_ready, w_out_valid, w_busy, w_op_cin;
  logic [31:0] w_op_a, w_op_b;
  logic [7:0]  w_out_data;
  assign w_in_ready  = sel ? ir1 : ir0;
  assign w_out_valid = sel ? ov1 : ov0;
  assign w_busy      = sel ? bz1 : bz0;
  assign w_op_cin    = sel ? oc1 : oc0;
  assign w_op_a      = sel ? oa1 : oa0;
  assign w_op_b      = sel ? ob1 : ob0;
  assign w_out_data  = sel ? od1 : od0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one input byte and hold it until accepted; returns at the following negedge.
  task automatic send_byte(input logic [7:0] d, input logic c);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    while (!w_in_ready && k < 50) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (!w_in_ready) chk("in_ready_timeout", 64'(w_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input int settle, input bit hold, output int t_first);
    int k, got, p;
    t_first = 0;
    for (int g = 0; g < 8; g++) begin
      // Only byte 0 carries the real carry-in; later bytes carry its inverse.
      send_byte(g < 4 ? v.a[8*g +: 8] : v.b[8*(g-4) +: 8], g == 0 ? v.cin : ~v.cin);
      if (g == 0) t_first = cyc;
    end
    in_valid = hold;
    in_data  = 8'($urandom);
    chk("op_a_loaded", 64'(w_op_a), 64'(v.a));
    chk("op_b_loaded", 64'(w_op_b), 64'(v.b));
    chk("op_cin_loaded", 64'(w_op_cin), 64'(v.cin));
    chk("busy_after_load", 64'(w_busy), 64'd1);
    k = 0;
    while (!w_out_valid && k < 40) begin
      chk("in_ready_wait", 64'(w_in_ready), 64'd0);
      @(posedge clk);
      k++;
      @(negedge clk);
      if (hold) in_data = 8'($urandom);
    end
    chk("settle_latency", 64'(k), 64'(settle));
    got = 0;
    p   = 0;
    k   = 0;
    while (got < 5 && k < 100) begin
      if (hold) in_data = 8'($urandom);
      chk("out_valid_held", 64'(w_out_valid), 64'd1);
      chk("out_byte", 64'(w_out_data), 64'(v.exp[8*got +: 8]));
      chk("in_ready_out", 64'(w_in_ready), 64'd0);
      chk("op_a_stable", 64'(w_op_a), 64'(v.a));
      chk("op_b_stable", 64'(w_op_b), 64'(v.b));
      out_ready = v.rdy[p % 8];
      p++;
      @(posedge clk);
      if (out_ready) got++;
      @(negedge clk);
      k++;
    end
    if (got < 5) chk("out_timeout", 64'(got), 64'd5);
    out_ready = 1'b0;
    chk("out_valid_done", 64'(w_out_valid), 64'd0);
    chk("out_data_done", 64'(w_out_data), 64'd0);
    chk("in_ready_done", 64'(w_in_ready), 64'd1);
    chk("busy_done", 64'(w_busy), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[7];
  vec_t v;
  int   t1, t2, k, cnt;

  initial begin
    vecs[0] = '{a: 32'h0000_0001, b: 32'hFFFF_FFFF, cin: 1'b0, exp: 40'h01_0000_0000, rdy: 8'hFF};
    vecs[1] = '{a: 32'h1234_5678, b: 32'h1111_1111, cin: 1'b1, exp: 40'h00_2345_678A, rdy: 8'b1001_1001};
    vecs[2] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, exp: 40'h01_0000_0000, rdy: 8'b0101_0110};
    vecs[3] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, exp: 40'h01_FFFF_FFFF, rdy: 8'hFF};
    vecs[4] = '{a: 32'h0000_0000, b: 32'h0000_0000, cin: 1'b0, exp: 40'h00_0000_0000, rdy: 8'b0011_0011};
    vecs[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, exp: 40'h01_0000_0000, rdy: 8'hFF};
    vecs[6] = '{a: 32'hDEAD_BEEF, b: 32'h0101_0101, cin: 1'b0, exp: 40'h00_DFAE_BFF0, rdy: 8'b1110_1101};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_cin = 1'b0; out_ready = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_op_a", 64'(w_op_a), 64'd0);
    chk("rst_op_b", 64'(w_op_b), 64'd0);
    chk("rst_op_cin", 64'(w_op_cin), 64'd0);
    chk("rst_out_valid", 64'(w_out_valid), 64'd0);
    chk("rst_out_data", 64'(w_out_data), 64'd0);
    chk("rst_in_ready", 64'(w_in_ready), 64'd1);
    chk("rst_busy", 64'(w_busy), 64'd0);

    // Table-driven transactions on the SETTLE=2 instance; odd entries keep in_valid high.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], 2, (i % 2) == 1, t1);
    end
    in_valid = 1'b0;

    // Reset after 5 input bytes, then a clean fresh load.
    for (int g = 0; g < 5; g++) send_byte(8'hA0 + 8'(g), 1'b1);
    in_valid = 1'b0;
    pulse_reset();
    chk("mid_rst_op_a", 64'(w_op_a), 64'd0);
    chk("mid_rst_op_b", 64'(w_op_b), 64'd0);
    chk("mid_rst_op_cin", 64'(w_op_cin), 64'd0);
    chk("mid_rst_out_valid", 64'(w_out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(w_out_data), 64'd0);
    chk("mid_rst_in_ready", 64'(w_in_ready), 64'd1);
    run_txn(vecs[2], 2, 1'b0, t1);

    // Reset while result bytes are pending: nothing may be emitted afterwards.
    for (int g = 0; g < 8; g++) send_byte(8'h55, 1'b0);
    in_valid = 1'b0;
    k = 0;
    while (!w_out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("pre_rst_out_valid", 64'(w_out_valid), 64'd1);
    pulse_reset();
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (w_out_valid) cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("no_output_after_reset", 64'(cnt), 64'd0);
    chk("post_rst_op_a", 64'(w_op_a), 64'd0);
    run_txn(vecs[6], 2, 1'b0, t1);

    // SETTLE=1 instance: two back-to-back transactions with continuous valid/ready.
    sel = 1'b1;
    pulse_reset();
    v = vecs[1];
    v.rdy = 8'hFF;
    run_txn(v, 1, 1'b1, t1);
    v = vecs[3];
    v.rdy = 8'hFF;
    run_txn(v, 1, 1'b1, t2);
    in_valid = 1'b0;
    chk("txn_period_settle1", 64'(t2 - t1), 64'd14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/byte_serial_adder_ctrl.md
Name: byte_serial_adder_ctrl

Overview:
- Byte-serial front/back end for the team's combinational 32-bit adders (carry-increment and ripple variants).
- Collects operands A and B as a stream of bytes over a valid/ready input port, then holds them stable on registered outputs that drive the adder.
- Waits a configurable settle window (a multicycle path) and captures the adder's sum and carry-out.
- Returns the result as a byte stream over a valid/ready output port.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8. N = WIDTH/8.
- SETTLE, 2, cycles the adder inputs are held before the result is captured; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data and in_cin are valid this cycle.
- in_ready  output  1  block accepts an input byte this cycle.
- in_data  input  8  operand byte.
- in_cin  input  1  carry-in; sampled only with byte 0.
- op_a  output  WIDTH  registered operand A, to the adder.
- op_b  output  WIDTH  registered operand B, to the adder.
- op_cin  output  1  registered carry-in, to the adder.
- add_sum  input  WIDTH  sum from the adder.
- add_cout  input  1  carry-out from the adder.
- out_valid  output  1  out_data holds a valid result byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  8  result byte.
- busy  output  1  high in every state except LOAD.

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-low (rst_n).
  - rst_n low at a rising edge forces: state=LOAD, byte_cnt=0, settle_cnt=0, op_a=0, op_b=0, op_cin=0, result regs=0, out_valid=0, out_data=0.
  - in_ready and busy are decodes of state: in_ready=1 and busy=0 in the first cycle after reset.
  - Reset mid-operation (any state) discards partial operands and any pending output bytes. No byte is emitted after reset.
- States: LOAD, WAIT, OUT.
- LOAD:
  - in_ready=1.
  - A byte transfer is in_valid & in_ready at a rising edge.
  - Transfer k (byte_cnt=k, 0..2N-1) writes in_data into:
    - op_a[8k+7:8k] for k<N (A is sent LS byte first);
    - op_b[8(k-N)+7:8(k-N)] for k>=N.
  - At k=0, op_cin<=in_cin.
  - Operand registers update byte by byte. The adder output is ignored until capture.
  - Transfer with k=2N-1: byte_cnt<=0, settle_cnt<=SETTLE, go to WAIT.
- WAIT:
  - in_ready=0. op_a, op_b and op_cin are held stable.
  - settle_cnt decrements each cycle.
  - In the cycle where settle_cnt==1, the next edge captures add_sum and add_cout, sets out_valid=1, loads out_data=add_sum[7:0], and goes to OUT.
  - Latency: last input byte accepted at edge t means out_valid=1 in the cycle after edge t+SETTLE. Inputs are held for exactly SETTLE full cycles.
- OUT:
  - Emits N+1 bytes, LS first: sum bytes 0..N-1, then {7'b0, cout}.
  - A transfer is out_valid & out_ready at a rising edge; the next byte is presented in the following cycle.
  - While out_ready=0, out_data and out_valid hold unchanged (no drop, no duplicate).
  - When the final byte is transferred: out_valid<=0, out_data<=0, go to LOAD; in_ready=1 the next cycle.
  - No bubble is required between consecutive output bytes.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; in_data is not stored.
  - out_valid, once high, never drops until the transfer completes.
  - in_valid and in_ready are independent: the upstream may hold in_valid high continuously.
- Operand registers keep their values after capture until overwritten by the next load. op_a and op_b are never cleared except by reset.
- Arithmetic is performed entirely by the external adder; this block does not add. The carry appears only in the final output byte.

Test Plan:
- WIDTH=32, SETTLE=2, real 32-bit adder attached. Send bytes 01 00 00 00 FF FF FF FF with cin=0 -> op_a=0x00000001, op_b=0xFFFFFFFF; output 00 00 00 00 01; out_valid first high 3 cycles after the last input edge.
- A=0x12345678, B=0x11111111, cin=1, out_ready toggling 1,0,0,1 -> output bytes 8A 67 45 23 00; each byte held stable during stalls; no repeat or skip.
- Hold in_valid=1 with random data throughout WAIT and OUT -> no op_a/op_b change and in_ready=0 until the final output byte is accepted; then LOAD resumes with byte 0.
- Pull rst_n low for 1 cycle after 5 input bytes -> all outputs 0, in_ready=1 next cycle. A fresh 8-byte load of A=0xFFFFFFFF, B=0x00000000, cin=1 -> output 00 00 00 00 01.
- SETTLE=1: last input edge t -> out_valid at t+2. Two back-to-back transactions with out_ready=1 and in_valid=1 continuously -> results match the adder model; cycle count per transaction = 8 + 1 + 5 + idle.
